alu_regfile: RTL and testbench



---
 rtl/alu_regfile_pkg.sv | 28 ++
 rtl/alu_flag_reg.sv | 27 ++
 rtl/alu_regfile.sv | 83 ++++++++
 tb/tb_alu_regfile.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_regfile_pkg.sv
// Shared widths and flag bit positions for the ALU register file and the
// branch/control logic that reads the latched flags.
package alu_regfile_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    localparam int FLAG_W   = 5;
    localparam int FLAG_ZRO = 0;
    localparam int FLAG_NEG = 1;
    localparam int FLAG_SO  = 2;
    localparam int FLAG_CO  = 3;
    localparam int FLAG_OVR = 4;

    function automatic logic [FLAG_W-1:0] pack_flags(input logic ovr, input logic co,
                                                      input logic so, input logic neg,
                                                      input logic zro);
        logic [FLAG_W-1:0] f;
        f           = '0;
        f[FLAG_OVR] = ovr;
        f[FLAG_CO]  = co;
        f[FLAG_SO]  = so;
        f[FLAG_NEG] = neg;
        f[FLAG_ZRO] = zro;
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Enabled status register holding the ALU condition flags for the next
// instruction's branch decision.
module alu_flag_reg
    import alu_regfile_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [FLAG_W-1:0] flags_i,
    output logic [FLAG_W-1:0] flags_o
);

    logic [FLAG_W-1:0] flags_q, flags_d;

    always_comb begin
        flags_d = flags_q;
        if (en_i) flags_d = flags_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) flags_q <= '0;
        else         flags_q <= flags_d;
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/alu_regfile.sv
// Two-read/one-write register file feeding the ALU operands, with a write
// counter and the latched ALU flag register.
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] RA_ADDR,
    input  logic [ADDR_W-1:0] RB_ADDR,
    output logic [DATA_W-1:0] A_OUT,
    output logic [DATA_W-1:0] B_OUT,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              FLAG_EN,
    input  logic              ZRO_IN,
    input  logic              NEG_IN,
    input  logic              SO_IN,
    input  logic              CO_IN,
    input  logic              OVR_IN,
    output logic [FLAG_W-1:0] FLAGS,
    output logic [7:0]        WR_COUNT
);

    localparam int NREG = 2 ** ADDR_W;
    localparam bit ZR   = (ZERO_REG != 0);

    logic [NREG-1:0][DATA_W-1:0] rf;
    logic                        wr_acc;
    logic [7:0]                  cnt_q, cnt_d;

    // A discarded write to the hardwired zero register is not "accepted".
    assign wr_acc = WR_EN && !(ZR && (WR_ADDR == '0));

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (ZR && i == 0) begin : g_zero
            assign rf[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] mem_q, mem_d;

            always_comb begin
                mem_d = mem_q;
                if (wr_acc && WR_ADDR == ADDR_W'(i)) mem_d = WR_DATA;
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) mem_q <= '0;
                else        mem_q <= mem_d;
            end

            assign rf[i] = mem_q;
        end
    end

    // Reads come from stored state, so a same-cycle write shows the old value.
    assign A_OUT = rf[RA_ADDR];
    assign B_OUT = rf[RB_ADDR];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign WR_COUNT = cnt_q;

    alu_flag_reg u_flag_reg (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .en_i    (FLAG_EN),
        .flags_i (pack_flags(OVR_IN, CO_IN, SO_IN, NEG_IN, ZRO_IN)),
        .flags_o (FLAGS)
    );

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: reset, read/write, zero register, flags
// and write-counter saturation.
module tb_alu_regfile;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [2:0] RA_ADDR, RB_ADDR, WR_ADDR;
    logic [7:0] A_OUT, B_OUT, WR_DATA;
    logic       WR_EN, FLAG_EN;
    logic       ZRO_IN, NEG_IN, SO_IN, CO_IN, OVR_IN;
    logic [4:0] FLAGS;
    logic [7:0] WR_COUNT;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    alu_regfile #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .RA_ADDR  (RA_ADDR),
        .RB_ADDR  (RB_ADDR),
        .A_OUT    (A_OUT),
        .B_OUT    (B_OUT),
        .WR_EN    (WR_EN),
        .WR_ADDR  (WR_ADDR),
        .WR_DATA  (WR_DATA),
        .FLAG_EN  (FLAG_EN),
        .ZRO_IN   (ZRO_IN),
        .NEG_IN   (NEG_IN),
        .SO_IN    (SO_IN),
        .CO_IN    (CO_IN),
        .OVR_IN   (OVR_IN),
        .FLAGS    (FLAGS),
        .WR_COUNT (WR_COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        tick();
        WR_EN   = 1'b0;
    endtask

    task automatic set_flags_in(input logic ovr, input logic co, input logic so,
                                input logic neg, input logic zro);
        OVR_IN = ovr; CO_IN = co; SO_IN = so; NEG_IN = neg; ZRO_IN = zro;
    endtask

    initial begin
        RST_N = 1'b0;
        RA_ADDR = '0; RB_ADDR = '0; WR_ADDR = '0; WR_DATA = '0;
        WR_EN = 1'b0; FLAG_EN = 1'b0;
        set_flags_in(0, 0, 0, 0, 0);
        #12 RST_N = 1'b1;
        tick();

        // Dirty the state so the async reset has something to clear.
        FLAG_EN = 1'b1;
        set_flags_in(1, 1, 1, 1, 1);
        wr(3'd1, 8'hAA);
        FLAG_EN = 1'b0;
        chk("pre_cnt", WR_COUNT, 8'd1);
        chk("pre_flags", FLAGS, 5'h1F);
        RA_ADDR = 3'd1;
        #1 chk("pre_r1", A_OUT, 8'hAA);

        // Mid-cycle reset with a write pending: clears without an edge.
        WR_EN = 1'b1; WR_ADDR = 3'd2; WR_DATA = 8'h33;
        FLAG_EN = 1'b1;
        #1 RST_N = 1'b0;
        #1;
        for (int a = 0; a < 8; a++) begin
            RA_ADDR = 3'(a); RB_ADDR = 3'(a);
            #0.1;
            chk("rst_a", A_OUT, 8'h00);
            chk("rst_b", B_OUT, 8'h00);
        end
        chk("rst_flags", FLAGS, 5'h00);
        chk("rst_cnt", WR_COUNT, 8'h00);
        tick();
        chk("rst_hold_cnt", WR_COUNT, 8'h00);
        chk("rst_hold_flags", FLAGS, 5'h00);
        RA_ADDR = 3'd2;
        #0.1 chk("rst_hold_r2", A_OUT, 8'h00);
        WR_EN = 1'b0; FLAG_EN = 1'b0;
        set_flags_in(0, 0, 0, 0, 0);
        #1 RST_N = 1'b1;
        tick();

        // Write / readback.
        wr(3'd1, 8'hD0);
        wr(3'd2, 8'h75);
        RA_ADDR = 3'd1; RB_ADDR = 3'd2;
        #1;
        chk("rd_a", A_OUT, 8'hD0);
        chk("rd_b", B_OUT, 8'h75);
        chk("alu_sum", {1'b0, A_OUT} + {1'b0, B_OUT}, 9'h145);
        chk("cnt2", WR_COUNT, 8'd2);
        RB_ADDR = 3'd1;
        #1;
        chk("same_a", A_OUT, 8'hD0);
        chk("same_b", B_OUT, 8'hD0);

        // Read-during-write returns old data until the edge.
        wr(3'd3, 8'h29);
        RA_ADDR = 3'd3;
        WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 8'h55;
        #1 chk("rdw_old", A_OUT, 8'h29);
        tick();
        WR_EN = 1'b0;
        chk("rdw_new", A_OUT, 8'h55);
        chk("cnt4", WR_COUNT, 8'd4);

        // Zero register discards writes.
        wr(3'd0, 8'hF5);
        RA_ADDR = 3'd0;
        #1;
        chk("r0_read", A_OUT, 8'h00);
        chk("r0_cnt", WR_COUNT, 8'd4);

        // WR_EN=0 leaves contents alone.
        WR_ADDR = 3'd1; WR_DATA = 8'hEE;
        tick();
        RA_ADDR = 3'd1;
        #1;
        chk("noen_r1", A_OUT, 8'hD0);
        chk("noen_cnt", WR_COUNT, 8'd4);

        // Flags, updated on the same edge as a register write.
        FLAG_EN = 1'b1;
        set_flags_in(1, 1, 0, 0, 0);
        wr(3'd4, 8'h11);
        FLAG_EN = 1'b0;
        set_flags_in(0, 0, 0, 0, 0);
        chk("flags_set", FLAGS, 5'b11000);
        chk("flags_cnt", WR_COUNT, 8'd5);
        RB_ADDR = 3'd4;
        #1 chk("flags_r4", B_OUT, 8'h11);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("flags_hold", FLAGS, 5'b11000);
        end
        FLAG_EN = 1'b1;
        set_flags_in(0, 0, 1, 1, 1);
        tick();
        FLAG_EN = 1'b0;
        chk("flags_low", FLAGS, 5'b00111);

        // Saturation: 300 writes starting from a count of 5.
        for (int i = 0; i < 300; i++) begin
            wr(3'd5, 8'(i));
            if (i == 248) chk("sat_fe", WR_COUNT, 8'hFE);
            if (i == 249) chk("sat_ff", WR_COUNT, 8'hFF);
        end
        chk("sat_end", WR_COUNT, 8'hFF);
        RA_ADDR = 3'd5;
        #1 chk("sat_r5", A_OUT, 8'h2B);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
